// File: rtl/aes128_stream_feeder_pkg.sv
// Shared widths and helpers for the AES-128 stream feeder (package aes_feeder_pkg).
package aes_feeder_pkg;

    localparam int AES_BLK_W        = 128;
    localparam int AES_WORD_W       = 32;
    localparam int WORDS_PER_BLK    = 4;
    localparam int AES_CORE_LATENCY = 11;
    localparam int AES_FIFO_DEPTH   = 16;
    localparam int WORD_IDX_W       = $clog2(WORDS_PER_BLK);

    typedef logic [AES_BLK_W-1:0]  aes_blk_t;
    typedef logic [AES_WORD_W-1:0] aes_word_t;
    typedef logic [WORD_IDX_W-1:0] word_idx_t;

    // Place word number idx of a block; word 0 lands in the most significant lane.
    function automatic aes_blk_t insert_word(input aes_blk_t blk, input aes_word_t word,
                                             input word_idx_t idx);
        aes_blk_t r;
        r = blk;
        r[AES_BLK_W-1-AES_WORD_W*int'(idx) -: AES_WORD_W] = word;
        return r;
    endfunction

endpackage

// File: rtl/aes128_stream_feeder_if.sv
// Generic valid/ready stream bundle; used for the 32-bit word input and the 128-bit block output.
interface aes128_stream_feeder_if #(
    parameter int W = 32
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/aes128_stream_feeder_fifo.sv
// First-word-fall-through synchronous FIFO (module aes_feeder_fifo) holding finished ciphertext.
// Head is presented combinationally; occupancy is exported for the issue credit check.
module aes_feeder_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);
    // A pop on the same edge frees the slot, so push-while-full is fine in that case.
    assign push_ok = push_i && (!full || pop_ok);

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    // The upstream credit scheme must never let a push hit a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(push_i && full && !pop_ok));

endmodule

// File: rtl/aes128_stream_feeder.sv
// Stream front/back-end for a pipelined AES-128 encrypt core with no flow control of its own.
// Packs 32-bit words into blocks, issues them to the core under a credit limit equal to the
// output FIFO depth, follows each block with a valid shift register and captures ciphertext.
// Optional block counters are built when AES_FEEDER_STATS_EN is defined.
module aes128_stream_feeder
    import aes_feeder_pkg::*;
#(
    parameter int LATENCY    = AES_CORE_LATENCY,
    parameter int FIFO_DEPTH = AES_FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    input  aes_blk_t key_in_i,
    input  logic     key_load_i,
    output logic     key_ready_o,
    output aes_blk_t core_pt_o,
    output aes_blk_t core_key_o,
    input  aes_blk_t core_ct_i,
    aes128_stream_feeder_if.slave  s_if,
    aes128_stream_feeder_if.master m_if
`ifdef AES_FEEDER_STATS_EN
    ,
    output logic [31:0] blk_in_cnt_o,
    output logic [31:0] blk_out_cnt_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    word_idx_t        word_idx_q, word_idx_d;
    aes_blk_t         blk_q, blk_d;
    logic             blk_full_q, blk_full_d;
    aes_blk_t         core_pt_q;
    aes_blk_t         core_key_q;
    logic [LATENCY-1:0] vld_sr_q;
    logic [CW-1:0]    in_flight_q, in_flight_d;

    logic [CW-1:0]    fifo_count;
    aes_blk_t         fifo_head;
    logic             fifo_valid;
    logic [CW:0]      credit_used;
    logic             issue_now;
    logic             retire;
    logic             s_fire;
    logic             m_pop;
    logic             key_take;

    // Blocks in the core plus blocks waiting in the FIFO may never exceed the FIFO size.
    assign credit_used = {1'b0, in_flight_q} + {1'b0, fifo_count};
    assign issue_now   = blk_full_q && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign retire      = vld_sr_q[LATENCY-1];

    // The packer frees its buffer on the same edge it issues, so streaming never bubbles.
    assign s_if.ready  = rst_n && (!blk_full_q || issue_now);
    assign s_fire      = s_if.valid && s_if.ready;
    assign m_pop       = fifo_valid && m_if.ready;

    // Key changes only when nothing is buffered or travelling through the core.
    assign key_ready_o = (in_flight_q == '0) && (word_idx_q == '0) && !blk_full_q;
    assign key_take    = key_load_i && key_ready_o;

    // Packer next state: fill word lanes MSB-first, mark full after the last word.
    always_comb begin
        blk_d      = blk_q;
        word_idx_d = word_idx_q;
        blk_full_d = blk_full_q && !issue_now;
        if (s_fire) begin
            blk_d      = insert_word(blk_q, s_if.data, word_idx_q);
            word_idx_d = word_idx_q + 1'b1;
            if (word_idx_q == WORD_IDX_W'(WORDS_PER_BLK - 1)) begin
                blk_full_d = 1'b1;
            end
        end
    end

    // In-flight count: issue and retire on the same edge cancel out.
    always_comb begin
        in_flight_d = in_flight_q;
        case ({issue_now, retire})
            2'b10:   in_flight_d = in_flight_q + 1'b1;
            2'b01:   in_flight_d = in_flight_q - 1'b1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    // Packer, core drive registers, valid tracking and credit state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_q  <= '0;
            blk_q       <= '0;
            blk_full_q  <= 1'b0;
            core_pt_q   <= '0;
            core_key_q  <= '0;
            vld_sr_q    <= '0;
            in_flight_q <= '0;
        end else begin
            word_idx_q  <= word_idx_d;
            blk_q       <= blk_d;
            blk_full_q  <= blk_full_d;
            if (issue_now) core_pt_q  <= blk_q;
            if (key_take)  core_key_q <= key_in_i;
            vld_sr_q    <= {vld_sr_q[LATENCY-2:0], issue_now};
            in_flight_q <= in_flight_d;
        end
    end

    assign core_pt_o  = core_pt_q;
    assign core_key_o = core_key_q;

    aes_feeder_fifo #(
        .WIDTH (AES_BLK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (retire),
        .push_data_i (core_ct_i),
        .pop_i       (m_pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign m_if.data  = fifo_head;
    assign m_if.valid = fifo_valid;

`ifdef AES_FEEDER_STATS_EN
    logic [31:0] blk_in_cnt_q;
    logic [31:0] blk_out_cnt_q;

    // Free-running block counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_in_cnt_q  <= '0;
            blk_out_cnt_q <= '0;
        end else begin
            if (issue_now) blk_in_cnt_q  <= blk_in_cnt_q + 32'd1;
            if (m_pop)     blk_out_cnt_q <= blk_out_cnt_q + 32'd1;
        end
    end

    assign blk_in_cnt_o  = blk_in_cnt_q;
    assign blk_out_cnt_o = blk_out_cnt_q;
`endif

endmodule

// File: tb/tb_aes128_stream_feeder.sv
// Bench for aes128_stream_feeder: models the AES core, predicts ciphertext from accepted words.
module tb_aes128_stream_feeder;
    import aes_feeder_pkg::*;

    localparam int LAT   = AES_CORE_LATENCY;
    localparam int DEPTH = AES_FIFO_DEPTH;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         key_ready;
    logic [127:0] core_pt, core_key, core_ct;
`ifdef AES_FEEDER_STATS_EN
    logic [31:0]  blk_in_cnt, blk_out_cnt;
`endif

    aes128_stream_feeder_if #(.W(32))  s_bus ();
    aes128_stream_feeder_if #(.W(128)) m_bus ();

    always #5 clk = ~clk;

    aes128_stream_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in_i    (key_in),
        .key_load_i  (key_load),
        .key_ready_o (key_ready),
        .core_pt_o   (core_pt),
        .core_key_o  (core_key),
        .core_ct_i   (core_ct),
        .s_if        (s_bus),
        .m_if        (m_bus)
`ifdef AES_FEEDER_STATS_EN
        ,
        .blk_in_cnt_o  (blk_in_cnt),
        .blk_out_cnt_o (blk_out_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                b = {b[6:0], b[7]};
                s = s ^ b;
            end
            sbox_tab[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] k [16];
        logic [7:0] rc, a0, a1, a2, a3, w0, w1, w2, w3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int rr = 0; rr < 4; rr++)
                for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rnd != 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            w0 = sbox_tab[k[13]] ^ rc; w1 = sbox_tab[k[14]];
            w2 = sbox_tab[k[15]];      w3 = sbox_tab[k[12]];
            k[0] = k[0] ^ w0; k[1] = k[1] ^ w1; k[2] = k[2] ^ w2; k[3] = k[3] ^ w3;
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    // ---------------- core model: launch edge T, result sampled at edge T+LAT ----------------
    logic [127:0] ct_pipe [LAT-1];
    always @(posedge clk) begin
        ct_pipe[0] <= aes_enc(core_pt, core_key);
        for (int i = 1; i < LAT - 1; i++) ct_pipe[i] <= ct_pipe[i-1];
    end
    assign core_ct = ct_pipe[LAT-2];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model and output collector ----------------
    logic [127:0] ref_key = '0;
    logic [31:0]  wbuf [$];
    logic [127:0] exp_q [$];
    logic [127:0] got_q [$];
    int           got_cyc [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            wbuf.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete();
            ref_key = '0;
        end else begin
            if (key_load && key_ready) ref_key = key_in;
            if (s_bus.valid && s_bus.ready) begin
                wbuf.push_back(s_bus.data);
                if (wbuf.size() == 4) begin
                    exp_q.push_back(aes_enc({wbuf[0], wbuf[1], wbuf[2], wbuf[3]}, ref_key));
                    wbuf.delete();
                end
            end
            if (m_bus.valid && m_bus.ready) begin
                got_q.push_back(m_bus.data);
                got_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] tx_w [128];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) tx_w[i] = $urandom;
    endtask

    task automatic load_key(input logic [127:0] k);
        int to = 0;
        key_in = k;
        key_load = 1'b1;
        while (!key_ready && to < 200) begin step(); to++; end
        if (!key_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL key_ready_timeout got=0 want=1");
        end
        step();
        key_load = 1'b0;
    endtask

    task automatic send_words(input int n, output int stalls, output int last_edge);
        int to;
        stalls = 0;
        last_edge = 0;
        for (int i = 0; i < n; i++) begin
            s_bus.valid = 1'b1;
            s_bus.data  = tx_w[i];
            to = 0;
            while (!s_bus.ready && to < 1000) begin step(); to++; end
            stalls += to;
            if (!s_bus.ready) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout word=%0d got=ready_low want=ready_high", i);
                break;
            end
            last_edge = cyc + 1;
            step();
        end
        s_bus.valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        int to = 0;
        while (got_q.size() < n && to < 600) begin step(); to++; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step(); step(); step();
        n_cmp++; if (s_bus.ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready got=%0b want=0", s_bus.ready); end
        n_cmp++; if (m_bus.valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got=%0b want=0", m_bus.valid); end
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL rst_key_ready got=%0b want=1", key_ready); end
        n_cmp++; if (core_pt !== '0) begin n_bad++; $display("FAIL rst_core_pt got=%h want=0", core_pt); end
        n_cmp++; if (core_key !== '0) begin n_bad++; $display("FAIL rst_core_key got=%h want=0", core_key); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (s_bus.ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_s_ready got=%0b want=1", s_bus.ready); end
        step();
        n_cmp++; if (m_bus.valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_m_valid got=%0b want=0", m_bus.valid); end
    endtask

    task automatic test_fips();
        int stalls, n4;
        load_key(FIPS_KEY);
        n_cmp++; if (core_key !== FIPS_KEY) begin n_bad++; $display("FAIL fips_core_key got=%h want=%h", core_key, FIPS_KEY); end
        m_bus.ready = 1'b1;
        tx_w[0] = 32'h00112233; tx_w[1] = 32'h44556677; tx_w[2] = 32'h8899aabb; tx_w[3] = 32'hccddeeff;
        send_words(4, stalls, n4);
        wait_outputs(1);
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL fips_count got=%0d want=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== FIPS_CT) begin n_bad++; $display("FAIL fips_ct got=%h want=%h", got_q[0], FIPS_CT); end
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL fips_model got=%h want=%h", got_q[0], exp_q[0]); end
            n_cmp++; if (got_cyc[0] != n4 + LAT + 1) begin n_bad++; $display("FAIL fips_latency got_edge=%0d want_edge=%0d", got_cyc[0], n4 + LAT + 1); end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int stalls, last;
        load_key({$urandom, $urandom, $urandom, $urandom});
        m_bus.ready = 1'b1;
        fill_rand(32);
        send_words(32, stalls, last);
        n_cmp++; if (stalls != 0) begin n_bad++; $display("FAIL b2b_stalls got=%0d want=0", stalls); end
        wait_outputs(8);
        n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL b2b_count got=%0d want=8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
            if (i > 0) begin
                n_cmp++; if (got_cyc[i] - got_cyc[i-1] != 4) begin n_bad++; $display("FAIL b2b_spacing[%0d] got=%0d want=4", i, got_cyc[i] - got_cyc[i-1]); end
            end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int i = 0, idle = 0, guard = 0;
        load_key({$urandom, $urandom, $urandom, $urandom});
        m_bus.ready = 1'b0;
        fill_rand(80);
        while (i < 80 && idle < 40 && guard < 2000) begin
            s_bus.valid = 1'b1;
            s_bus.data  = tx_w[i];
            if (s_bus.ready) begin i++; idle = 0; end else idle++;
            step();
            guard++;
        end
        n_cmp++; if (i != (DEPTH + 1) * 4) begin n_bad++; $display("FAIL bp_words_accepted got=%0d want=%0d", i, (DEPTH + 1) * 4); end
        n_cmp++; if (s_bus.ready !== 1'b0) begin n_bad++; $display("FAIL bp_s_ready got=%0b want=0", s_bus.ready); end
        n_cmp++; if (m_bus.valid !== 1'b1) begin n_bad++; $display("FAIL bp_m_valid got=%0b want=1", m_bus.valid); end
        m_bus.ready = 1'b1;
        guard = 0;
        while (i < 80 && guard < 2000) begin
            s_bus.valid = 1'b1;
            s_bus.data  = tx_w[i];
            if (s_bus.ready) i++;
            step();
            guard++;
        end
        s_bus.valid = 1'b0;
        wait_outputs(20);
        n_cmp++; if (got_q.size() != 20) begin n_bad++; $display("FAIL bp_count got=%0d want=20", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 20; j++) begin
            n_cmp++; if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL bp_data[%0d] got=%h want=%h", j, got_q[j], exp_q[j]); end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_key_change();
        logic [127:0] ka, kb;
        int stalls, n8, to, bad_key;
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        load_key(ka);
        m_bus.ready = 1'b1;
        fill_rand(8);
        send_words(8, stalls, n8);
        key_in = kb;
        key_load = 1'b1;
        n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL kc_key_ready_busy got=%0b want=0", key_ready); end
        to = 0; bad_key = 0;
        while (!key_ready && to < 100) begin
            if (core_key !== ka) bad_key++;
            step();
            to++;
        end
        n_cmp++; if (bad_key != 0) begin n_bad++; $display("FAIL kc_key_held got=%0d_bad_cycles want=0", bad_key); end
        n_cmp++; if (cyc != n8 + 1 + LAT) begin n_bad++; $display("FAIL kc_ready_edge got=%0d want=%0d", cyc, n8 + 1 + LAT); end
        step();
        key_load = 1'b0;
        n_cmp++; if (core_key !== kb) begin n_bad++; $display("FAIL kc_new_key got=%h want=%h", core_key, kb); end
        fill_rand(4);
        send_words(4, stalls, n8);
        wait_outputs(3);
        n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL kc_count got=%0d want=3", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 3; j++) begin
            n_cmp++; if (got_q[j] !== exp_q[j]) begin n_bad++; $display("FAIL kc_data[%0d] got=%h want=%h", j, got_q[j], exp_q[j]); end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int stalls, last, vcount;
        load_key({$urandom, $urandom, $urandom, $urandom});
        m_bus.ready = 1'b0;
        fill_rand(20);
        send_words(20, stalls, last);
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_bus.valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_m_valid got=%0b want=0", m_bus.valid); end
        n_cmp++; if (s_bus.ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_s_ready got=%0b want=0", s_bus.ready); end
        step(); step(); step();
        rst_n = 1'b1;
        m_bus.ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            if (m_bus.valid) vcount++;
            step();
        end
        n_cmp++; if (vcount != 0) begin n_bad++; $display("FAIL mid_stale_valid got=%0d want=0", vcount); end
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL mid_stale_out got=%0d want=0", got_q.size()); end
        n_cmp++; if (core_key !== '0) begin n_bad++; $display("FAIL mid_core_key got=%h want=0", core_key); end
        load_key(FIPS_KEY);
        tx_w[0] = 32'h00112233; tx_w[1] = 32'h44556677; tx_w[2] = 32'h8899aabb; tx_w[3] = 32'hccddeeff;
        send_words(4, stalls, last);
        wait_outputs(1);
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL mid_fips_count got=%0d want=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== FIPS_CT) begin n_bad++; $display("FAIL mid_fips_ct got=%h want=%h", got_q[0], FIPS_CT); end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

`ifdef AES_FEEDER_STATS_EN
    task automatic test_stats();
        int stalls, last;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        load_key({$urandom, $urandom, $urandom, $urandom});
        m_bus.ready = 1'b0;
        fill_rand(12);
        send_words(12, stalls, last);
        for (int i = 0; i < LAT + 6; i++) step();
        m_bus.ready = 1'b1;
        step(); step();
        m_bus.ready = 1'b0;
        step();
        n_cmp++; if (blk_in_cnt !== 32'd3) begin n_bad++; $display("FAIL stats_in got=%0d want=3", blk_in_cnt); end
        n_cmp++; if (blk_out_cnt !== 32'd2) begin n_bad++; $display("FAIL stats_out got=%0d want=2", blk_out_cnt); end
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL stats_pops got=%0d want=2", got_q.size()); end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask
`endif

    initial begin
        s_bus.valid = 1'b0;
        s_bus.data  = '0;
        m_bus.ready = 1'b0;
        build_sbox();
        #1;
        test_reset();
        test_fips();
        test_back_to_back();
        test_backpressure();
        test_key_change();
        test_reset_mid();
`ifdef AES_FEEDER_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
